// File: rtl/seq_nonrestoring_divider_pkg.sv
// ============================================================================
// seq_nonrestoring_divider_pkg : shared state encoding and sizing helpers
// Revision 1.0
// ============================================================================
`default_nettype none

package seq_nonrestoring_divider_pkg;

  localparam int N_MIN = 2;
  localparam int N_MAX = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  // Iteration counter must be able to hold the value N itself.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_nonrestoring_divider_if.sv
// ============================================================================
// seq_nonrestoring_divider_if : start/busy/done handshake and operand/result bus
// Revision 1.0
// ============================================================================
`default_nettype none

interface seq_nonrestoring_divider_if #(
  parameter int N = 8
);

  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

`default_nettype wire

// File: rtl/seq_nonrestoring_divider_add_sub_unit.sv
// ============================================================================
// add_sub_unit : combinational W-bit adder/subtractor (sub => a + ~b + 1)
// Revision 1.0
// ============================================================================
`default_nettype none

module add_sub_unit #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] result,
  output logic         cout
);

  logic [W-1:0] w_b_eff;

  assign w_b_eff = sub ? ~b : b;
  assign {cout, result} = {1'b0, a} + {1'b0, w_b_eff} + {{W{1'b0}}, sub};

endmodule

`default_nettype wire

// File: rtl/seq_nonrestoring_divider.sv
// ============================================================================
// seq_nonrestoring_divider : unsigned N-bit non-restoring divider, 1 bit/clock
// Revision 1.0
// ============================================================================
`default_nettype none

module seq_nonrestoring_divider
  import seq_nonrestoring_divider_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  seq_nonrestoring_divider_if.slave bus
);

  localparam int W     = N + 1;
  localparam int CNT_W = cnt_width(N);

  div_state_e       r_state;
  div_state_e       w_state_next;
  logic [N-1:0]     r_d;
  logic [N-1:0]     r_q;
  logic [W-1:0]     r_r;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dz;
  logic             r_busy;
  logic             r_done;
  logic [N-1:0]     r_quot;
  logic [N-1:0]     r_rem;
  logic             r_dz_out;

  logic [W-1:0]     w_as_a;
  logic [W-1:0]     w_as_b;
  logic [W-1:0]     w_as_res;
  logic             w_as_sub;
  logic             w_unused_cout;

  // RUN feeds the shifted partial remainder; FIX feeds R for the sign correction.
  always_comb begin
    w_as_a   = r_r;
    w_as_b   = {1'b0, r_d};
    w_as_sub = 1'b0;
    if (r_state == RUN) begin
      w_as_a   = {r_r[N-1:0], r_q[N-1]};
      w_as_sub = ~r_r[N];
    end
  end

  add_sub_unit #(
    .W (W)
  ) u_add_sub (
    .a      (w_as_a),
    .b      (w_as_b),
    .sub    (w_as_sub),
    .result (w_as_res),
    .cout   (w_unused_cout)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_next = (bus.divisor == '0) ? FIX : RUN;
        end
      end
      RUN: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_next = FIX;
        end
      end
      FIX:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d      <= '0;
      r_q      <= '0;
      r_r      <= '0;
      r_cnt    <= '0;
      r_dz     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_dz_out <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_d    <= bus.divisor;
            r_q    <= bus.dividend;
            r_r    <= '0;
            r_cnt  <= CNT_W'(N);
            r_dz   <= (bus.divisor == '0);
            r_busy <= 1'b1;
          end
        end
        RUN: begin
          r_r   <= w_as_res;
          r_q   <= {r_q[N-2:0], ~w_as_res[N]};
          r_cnt <= r_cnt - CNT_W'(1);
        end
        FIX: begin
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_dz_out <= r_dz;
          if (r_r[N]) begin
            r_r <= w_as_res;
          end
          if (r_dz) begin
            // Divide by zero: r_q still holds the untouched dividend.
            r_quot <= '1;
            r_rem  <= r_q;
          end else begin
            r_quot <= r_q;
            r_rem  <= r_r[N] ? w_as_res[N-1:0] : r_r[N-1:0];
          end
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dz_out;

endmodule

`default_nettype wire

// File: tb/tb_seq_nonrestoring_divider.sv
// ============================================================================
// tb_seq_nonrestoring_divider : vector table, control corner cases, random run
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_seq_nonrestoring_divider;

  localparam int N = 8;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  seq_nonrestoring_divider_if #(.N(N)) bus ();

  seq_nonrestoring_divider #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dd;
    logic [7:0] dv;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         lat;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Called just after an active edge; the next edge is the accepting edge E0.
  task automatic run_div(input logic [7:0] dd, input logic [7:0] dv,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic dz, output int lat);
    bus.start    = 1'b1;
    bus.dividend = dd;
    bus.divisor  = dv;
    tick();
    bus.start    = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 8'($urandom);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    q  = bus.quotient;
    r  = bus.remainder;
    dz = bus.div_by_zero;
  endtask

  logic [7:0] q, r, dd, dv, eq, er;
  logic       dz, edz;
  int         lat, pulses;

  initial begin
    vecs[0] = '{dd: 8'd100, dv: 8'd7,   q: 8'd14,  r: 8'd2,  dz: 1'b0, lat: 9};
    vecs[1] = '{dd: 8'd255, dv: 8'd1,   q: 8'd255, r: 8'd0,  dz: 1'b0, lat: 9};
    vecs[2] = '{dd: 8'd5,   dv: 8'd9,   q: 8'd0,   r: 8'd5,  dz: 1'b0, lat: 9};
    vecs[3] = '{dd: 8'd255, dv: 8'd255, q: 8'd1,   r: 8'd0,  dz: 1'b0, lat: 9};
    vecs[4] = '{dd: 8'd42,  dv: 8'd0,   q: 8'd255, r: 8'd42, dz: 1'b1, lat: 1};
    vecs[5] = '{dd: 8'd42,  dv: 8'd6,   q: 8'd7,   r: 8'd0,  dz: 1'b0, lat: 9};

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #12;
    check("reset_busy", {31'd0, bus.busy}, 0);
    check("reset_done", {31'd0, bus.done}, 0);
    check("reset_quot", {24'd0, bus.quotient}, 0);
    check("reset_rem",  {24'd0, bus.remainder}, 0);
    check("reset_dz",   {31'd0, bus.div_by_zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Busy profile of a plain 100/7.
    bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("busy_E%0d", k), {31'd0, bus.busy}, 1);
      check($sformatf("nodone_E%0d", k), {31'd0, bus.done}, 0);
    end
    tick();
    check("busy_E9", {31'd0, bus.busy}, 0);
    check("done_E9", {31'd0, bus.done}, 1);
    tick();
    check("done_pulse_E10", {31'd0, bus.done}, 0);
    check("quot_hold_E10", {24'd0, bus.quotient}, 14);

    foreach (vecs[i]) begin
      run_div(vecs[i].dd, vecs[i].dv, q, r, dz, lat);
      check($sformatf("vec%0d_lat", i),  lat, vecs[i].lat);
      check($sformatf("vec%0d_quot", i), {24'd0, q}, {24'd0, vecs[i].q});
      check($sformatf("vec%0d_rem", i),  {24'd0, r}, {24'd0, vecs[i].r});
      check($sformatf("vec%0d_dz", i),   {31'd0, dz}, {31'd0, vecs[i].dz});
    end

    // 200/3 with a second start at E4 that must be ignored.
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd3;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 8'd2;
    tick();
    bus.start = 1'b0;
    lat = -1;
    for (int k = 5; k <= 40; k++) begin
      tick();
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("ignore_lat",  lat, 9);
    check("ignore_quot", {24'd0, bus.quotient}, 66);
    check("ignore_rem",  {24'd0, bus.remainder}, 2);

    // Start issued in the done cycle is accepted with no dead cycle.
    check("b2b_in_done", {31'd0, bus.done}, 1);
    run_div(8'd9, 8'd2, q, r, dz, lat);
    check("b2b_lat",  lat, 9);
    check("b2b_quot", {24'd0, q}, 4);
    check("b2b_rem",  {24'd0, r}, 1);

    // Reset at E3 of 100/7 clears outputs at once and suppresses done.
    bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, bus.busy}, 0);
    check("arst_done", {31'd0, bus.done}, 0);
    check("arst_quot", {24'd0, bus.quotient}, 0);
    check("arst_rem",  {24'd0, bus.remainder}, 0);
    check("arst_dz",   {31'd0, bus.div_by_zero}, 0);
    tick(); tick();
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (bus.done === 1'b1) pulses++;
    end
    check("arst_no_done", pulses, 0);

    // Random operands against plain integer division.
    for (int i = 0; i < 1000; i++) begin
      dd = 8'($urandom);
      dv = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      if (dv == 8'd0) begin
        eq = 8'hFF; er = dd; edz = 1'b1;
      end else begin
        eq = dd / dv; er = dd % dv; edz = 1'b0;
      end
      run_div(dd, dv, q, r, dz, lat);
      check($sformatf("rnd%0d_%0d/%0d_lat", i, dd, dv), lat, edz ? 1 : 9);
      check($sformatf("rnd%0d_%0d/%0d_quot", i, dd, dv), {24'd0, q}, {24'd0, eq});
      check($sformatf("rnd%0d_%0d/%0d_rem", i, dd, dv), {24'd0, r}, {24'd0, er});
      check($sformatf("rnd%0d_%0d/%0d_dz", i, dd, dv), {31'd0, dz}, {31'd0, edz});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_nonrestoring_divider.md
Name: seq_nonrestoring_divider

Overview:
- Multi-cycle unsigned N-bit divider built on the team's N-bit add/subtract datapath.
- Division is the inverse of the add/sub path: it reuses one (N+1)-bit add/sub unit iteratively, one quotient bit per clock, using non-restoring division.
- Sits beside the arithmetic blocks as the first sequential arithmetic unit, with a start/busy/done handshake toward a controller.

Parameters:
- N, 8, operand width in bits for dividend, divisor, quotient and remainder; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a division; sampled only in IDLE.
- dividend  input  N  unsigned dividend; captured on the accepting edge.
- divisor  input  N  unsigned divisor; captured on the accepting edge.
- busy  output  1  high from the edge after acceptance until the edge that asserts done.
- done  output  1  one-cycle pulse; results valid in the same cycle.
- quotient  output  N  registered quotient; holds until the next done.
- remainder  output  N  registered remainder; holds until the next done.
- div_by_zero  output  1  registered flag; updated with each done.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internal registers cleared. Reset mid-operation aborts the division; no done is produced.
- States: IDLE, RUN, FIX.
- IDLE, start=1 at edge E0:
  - Capture D=divisor, Q=dividend, R=0 ((N+1)-bit signed), iteration count=N, busy=1.
  - If divisor==0, go to FIX with the dz flag set. Otherwise go to RUN.
- RUN, each edge (N edges, E1..EN):
  - {R,Q} shifts left one bit.
  - If the pre-shift R>=0, R=shifted R - D. Otherwise R=shifted R + D.
  - Q[0] = ~R_new[N].
  - Count decrements; leave for FIX when count reaches 1 on this edge.
- FIX, one edge:
  - If R<0, R=R+D.
  - quotient=Q and remainder=R[N-1:0].
  - done=1 for exactly one cycle, busy=0, next state IDLE.
- Divide by zero: FIX at edge E1 sets quotient=all ones, remainder=dividend, div_by_zero=1, done at E1.
- div_by_zero=0 on every normal completion.
- Latency: normal division done is visible after edge E(N+1); divide by zero after E1.
- start while busy is ignored; operand inputs are don't-care while busy.
- Back-to-back operation: start in the done cycle is accepted, because state is already IDLE. Zero dead cycles.
- Arithmetic: the (N+1)-bit add/sub absorbs the sign. The carry-out is discarded. No overflow is possible for unsigned operands.

Decomposition:
- Shared header divider_defs: state encoding localparams (IDLE=2'd0, RUN=2'd1, FIX=2'd2) and the counter width clog2(N+1).
- One sub-module, add_sub_unit (combinational, W=N+1):
  - Inputs a, b, sub; outputs result and cout.
  - Subtraction is implemented as a + ~b + 1.
  - Instantiated once and shared by RUN and FIX.

Test Plan (N=8):
- dividend=100, divisor=7, start at E0 -> done after E9: quotient=14, remainder=2, div_by_zero=0; busy high E1..E8.
- 255/1 -> quotient=255, remainder=0.
- 5/9 (dividend<divisor) -> quotient=0, remainder=5.
- 255/255 -> quotient=1, remainder=0.
- 42/0 -> done after E1: quotient=255, remainder=42, div_by_zero=1. A following 42/6 returns 7, 0 with div_by_zero=0.
- Control cases:
  - 200/3 with a second start (9/2) at E4 -> second start ignored; result 66, 2.
  - Start 9/2 in the done cycle -> accepted; done 9 cycles later with 4, 1.
  - rst_n low at E3 of 100/7 -> all outputs 0 immediately; no done pulse afterwards.
- Randomized check: 1000 random operand pairs against the reference model dividend/divisor and dividend%divisor.
